// File: rtl/fp_addsub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_addsub_pkg : shared widths and exponent-compare encoding for the   |
// |                 FP add/sub datapath.                   Rev 1.0        |
// +----------------------------------------------------------------------+
package fp_addsub_pkg;
    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int SIG_W      = MANT_WIDTH + 4;
    localparam int SHIFT_W    = 5;

    typedef enum logic [1:0] {
        A_LT = 2'b00,
        A_GT = 2'b10,
        A_EQ = 2'b11
    } exp_disc_e;
endpackage
`default_nettype wire

// File: rtl/sticky_rshift.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sticky_rshift : combinational right shift folding lost bits into the  |
// |                 LSB (sticky).                          Rev 1.0        |
// +----------------------------------------------------------------------+
module sticky_rshift #(
    parameter int SIG_W   = 27,
    parameter int SHIFT_W = 5
) (
    input  logic [SIG_W-1:0]   i_sig,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_force,
    output logic [SIG_W-1:0]   o_sig
);
    logic [SIG_W-1:0] w_shifted;
    logic [SIG_W-1:0] w_lost_mask;
    logic             w_overflow;
    logic             w_lost_any;

    assign w_overflow  = i_force || (int'(i_shift) >= SIG_W);
    assign w_shifted   = i_sig >> i_shift;
    assign w_lost_mask = ~({SIG_W{1'b1}} << i_shift);
    assign w_lost_any  = |(i_sig & w_lost_mask);

    // Bit 0 is the sticky position, so anything shifted past it ORs in there.
    assign o_sig = w_overflow ? {{(SIG_W-1){1'b0}}, |i_sig}
                              : {w_shifted[SIG_W-1:1], w_shifted[0] | w_lost_any};
endmodule
`default_nettype wire

// File: rtl/mantissa_align_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mantissa_align_pipe : orders operands, restores hidden bits and       |
// |                       aligns the smaller significand (2 stages).      |
// |                                                        Rev 1.0        |
// +----------------------------------------------------------------------+
module mantissa_align_pipe #(
    parameter int EXP_WIDTH  = fp_addsub_pkg::EXP_WIDTH,
    parameter int MANT_WIDTH = fp_addsub_pkg::MANT_WIDTH,
    parameter int SIG_W      = MANT_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic                  sign_a,
    input  logic                  sign_b,
    input  logic [EXP_WIDTH-1:0]  exp_a,
    input  logic [EXP_WIDTH-1:0]  exp_b,
    input  logic [MANT_WIDTH-1:0] mant_a,
    input  logic [MANT_WIDTH-1:0] mant_b,
    input  logic [1:0]            exp_disc,
    input  logic [4:0]            shift_spaces,
    input  logic [EXP_WIDTH-1:0]  exp_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIG_W-1:0]      sig_large,
    output logic [SIG_W-1:0]      sig_small,
    output logic                  eff_sub,
    output logic                  res_sign,
    output logic [EXP_WIDTH-1:0]  exp_out,
    output logic                  swapped
);
    import fp_addsub_pkg::*;

    localparam int HSIG_W = MANT_WIDTH + 1;
    localparam logic [EXP_WIDTH:0] c_MAX_SHIFT = (EXP_WIDTH+1)'(31);

    logic                  w_hid_a, w_hid_b;
    logic [HSIG_W-1:0]     w_sig_a, w_sig_b;
    logic                  w_sb, w_eff_sub, w_swap, w_res_sign, w_equal_mag;
    logic [EXP_WIDTH:0]    w_exp_diff;
    logic                  w_big_shift;
    logic                  w_s1_advance, w_in_xfer;
    logic [SIG_W-1:0]      w_small_aligned;

    logic                  r_rdy_en;
    logic                  r1_valid;
    logic [HSIG_W-1:0]     r1_large, r1_small;
    logic [4:0]            r1_shift;
    logic                  r1_big, r1_eff_sub, r1_res_sign, r1_swapped;
    logic [EXP_WIDTH-1:0]  r1_exp;

    logic                  r2_valid;
    logic [SIG_W-1:0]      r2_sig_large, r2_sig_small;
    logic                  r2_eff_sub, r2_res_sign, r2_swapped;
    logic [EXP_WIDTH-1:0]  r2_exp;

    assign w_s1_advance = !r2_valid || out_ready;
    assign in_ready     = r_rdy_en && (!r1_valid || w_s1_advance);
    assign w_in_xfer    = in_valid && in_ready;

    assign w_hid_a     = |exp_a;
    assign w_hid_b     = |exp_b;
    assign w_sig_a     = {w_hid_a, mant_a};
    assign w_sig_b     = {w_hid_b, mant_b};
    assign w_sb        = sign_b ^ op_sub;
    assign w_eff_sub   = sign_a ^ w_sb;
    assign w_equal_mag = (exp_a == exp_b) && (mant_a == mant_b);

    // shift_spaces is truncated to 5 bits; recover far-apart exponents here.
    assign w_exp_diff  = (exp_a >= exp_b) ? ({1'b0, exp_a} - {1'b0, exp_b})
                                          : ({1'b0, exp_b} - {1'b0, exp_a});
    assign w_big_shift = w_exp_diff > c_MAX_SHIFT;

    always_comb begin
        w_swap = 1'b0;
        case (exp_disc)
            A_GT:    w_swap = 1'b0;
            A_LT:    w_swap = 1'b1;
            default: w_swap = (w_sig_b > w_sig_a);
        endcase
    end

    assign w_res_sign = (w_eff_sub && w_equal_mag) ? 1'b0
                                                   : (w_swap ? w_sb : sign_a);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en    <= 1'b0;
            r1_valid    <= 1'b0;
            r1_large    <= '0;
            r1_small    <= '0;
            r1_shift    <= '0;
            r1_big      <= 1'b0;
            r1_eff_sub  <= 1'b0;
            r1_res_sign <= 1'b0;
            r1_swapped  <= 1'b0;
            r1_exp      <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (in_ready) begin
                r1_valid <= in_valid;
            end
            if (w_in_xfer) begin
                r1_large    <= w_swap ? w_sig_b : w_sig_a;
                r1_small    <= w_swap ? w_sig_a : w_sig_b;
                r1_shift    <= shift_spaces;
                r1_big      <= w_big_shift;
                r1_eff_sub  <= w_eff_sub;
                r1_res_sign <= w_res_sign;
                r1_swapped  <= w_swap;
                r1_exp      <= exp_value;
            end
        end
    end

    sticky_rshift #(
        .SIG_W   (SIG_W),
        .SHIFT_W (5)
    ) u_sticky_rshift (
        .i_sig   ({r1_small, 3'b000}),
        .i_shift (r1_shift),
        .i_force (r1_big),
        .o_sig   (w_small_aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid     <= 1'b0;
            r2_sig_large <= '0;
            r2_sig_small <= '0;
            r2_eff_sub   <= 1'b0;
            r2_res_sign  <= 1'b0;
            r2_swapped   <= 1'b0;
            r2_exp       <= '0;
        end else if (w_s1_advance) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sig_large <= {r1_large, 3'b000};
                r2_sig_small <= w_small_aligned;
                r2_eff_sub   <= r1_eff_sub;
                r2_res_sign  <= r1_res_sign;
                r2_swapped   <= r1_swapped;
                r2_exp       <= r1_exp;
            end
        end
    end

    assign out_valid = r2_valid;
    assign sig_large = r2_sig_large;
    assign sig_small = r2_sig_small;
    assign eff_sub   = r2_eff_sub;
    assign res_sign  = r2_res_sign;
    assign exp_out   = r2_exp;
    assign swapped   = r2_swapped;
endmodule
`default_nettype wire

// File: tb/tb_mantissa_align_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mantissa_align_pipe : vector table, random traffic vs. reference   |
// |                          model, backpressure and reset sequences.     |
// |                                                        Rev 1.0        |
// +----------------------------------------------------------------------+
module tb_mantissa_align_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, op_sub, sign_a, sign_b;
    logic [7:0]  exp_a, exp_b, exp_value, exp_out;
    logic [22:0] mant_a, mant_b;
    logic [1:0]  exp_disc;
    logic [4:0]  shift_spaces;
    logic        out_valid, out_ready, eff_sub, res_sign, swapped;
    logic [26:0] sig_large, sig_small;

    typedef struct {
        logic        op, sa, sb;
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
    } stim_t;

    typedef struct {
        logic [26:0] sl, ss;
        logic        eff, rs, sw;
        logic [7:0]  ex;
    } res_t;

    typedef struct {
        stim_t s;
        res_t  e;
    } tvec_t;

    int    n_vec = 0;
    int    n_err = 0;
    stim_t cur;
    res_t  q[$];
    bit    mon_en = 1'b0;
    bit    hold_v = 1'b0;
    res_t  held;

    mantissa_align_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .sign_a(sign_a), .sign_b(sign_b),
        .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
        .exp_disc(exp_disc), .shift_spaces(shift_spaces), .exp_value(exp_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .sig_large(sig_large), .sig_small(sig_small), .eff_sub(eff_sub),
        .res_sign(res_sign), .exp_out(exp_out), .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input stim_t s);
        res_t        r;
        logic [23:0] a, b, sm;
        logic [58:0] wide;
        logic        sbe, swap;
        int          d;
        a    = {(s.ea != 8'd0), s.ma};
        b    = {(s.eb != 8'd0), s.mb};
        swap = (s.eb > s.ea) || ((s.eb == s.ea) && (b > a));
        d    = (s.ea > s.eb) ? int'(s.ea) - int'(s.eb) : int'(s.eb) - int'(s.ea);
        sbe  = s.sb ^ s.op;
        r.eff = s.sa ^ sbe;
        r.sw  = swap;
        r.rs  = swap ? sbe : s.sa;
        if (r.eff && (a == b) && (s.ea == s.eb)) r.rs = 1'b0;
        r.sl = {(swap ? b : a), 3'b000};
        sm   = swap ? a : b;
        if (d > 31) begin
            r.ss = {26'd0, |sm};
        end else begin
            wide = {sm, 35'd0} >> d;
            r.ss = wide[58:32];
            r.ss[0] = r.ss[0] | (|wide[31:0]);
        end
        r.ex = (s.ea > s.eb) ? s.ea : s.eb;
        return r;
    endfunction

    task automatic apply(input stim_t s, input logic v);
        logic [8:0] diff;
        cur      = s;
        in_valid = v;
        op_sub   = s.op;  sign_a = s.sa;  sign_b = s.sb;
        exp_a    = s.ea;  exp_b  = s.eb;
        mant_a   = s.ma;  mant_b = s.mb;
        exp_disc = (s.ea > s.eb) ? 2'b10 : ((s.ea < s.eb) ? 2'b00 : 2'b11);
        diff     = (s.ea > s.eb) ? ({1'b0, s.ea} - {1'b0, s.eb}) : ({1'b0, s.eb} - {1'b0, s.ea});
        shift_spaces = diff[4:0];
        exp_value    = (s.ea > s.eb) ? s.ea : s.eb;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.op = 1'($urandom); s.sa = 1'($urandom); s.sb = 1'($urandom);
        s.ea = 8'($urandom); s.ma = 23'($urandom); s.mb = 23'($urandom);
        case ($urandom % 4)
            0:       s.eb = s.ea;
            1:       s.eb = s.ea + 8'($urandom_range(0, 40));
            2:       s.eb = s.ea - 8'($urandom_range(0, 6));
            default: s.eb = 8'($urandom);
        endcase
        if (($urandom % 8) == 0) s.mb = s.ma;
        if (($urandom % 16) == 0) s.ea = 8'd0;
        return s;
    endfunction

    function automatic tvec_t mk(input logic op, sa, sb, input logic [7:0] ea, eb,
                                 input logic [22:0] ma, mb, input logic [26:0] sl, ss,
                                 input logic eff, rs, sw, input logic [7:0] ex);
        tvec_t t;
        t.s = '{op: op, sa: sa, sb: sb, ea: ea, eb: eb, ma: ma, mb: mb};
        t.e = '{sl: sl, ss: ss, eff: eff, rs: rs, sw: sw, ex: ex};
        return t;
    endfunction

    task automatic cmp_out(input string tag, input res_t e);
        chk({tag, "_sig_large"}, 32'(sig_large), 32'(e.sl));
        chk({tag, "_sig_small"}, 32'(sig_small), 32'(e.ss));
        chk({tag, "_eff_sub"},   32'(eff_sub),   32'(e.eff));
        chk({tag, "_res_sign"},  32'(res_sign),  32'(e.rs));
        chk({tag, "_swapped"},   32'(swapped),   32'(e.sw));
        chk({tag, "_exp_out"},   32'(exp_out),   32'(e.ex));
    endtask

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        res_t e;
        if (mon_en && !rst) begin
            if (hold_v) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_sig_small", 32'(sig_small), 32'(held.ss));
                chk("stall_sig_large", 32'(sig_large), 32'(held.sl));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    cmp_out("sb", e);
                end
            end
            if (in_valid && in_ready) q.push_back(model(cur));
            hold_v  = out_valid && !out_ready;
            held.sl = sig_large;
            held.ss = sig_small;
        end else begin
            hold_v = 1'b0;
        end
    end

    tvec_t tv[12];
    stim_t bp[4];

    initial begin
        stim_t z;
        int    k;
        bit    fell;
        z = '{op: 1'b0, sa: 1'b0, sb: 1'b0, ea: 8'd0, eb: 8'd0, ma: 23'd0, mb: 23'd0};
        rst = 1'b1; out_ready = 1'b0;
        apply(z, 1'b0);

        tv[0]  = mk(0,0,0, 127,126, 23'h400000, 23'h0,      27'h6000000, 27'h2000000, 0,0,0, 127);
        tv[1]  = mk(1,0,0, 130,130, 23'h100000, 23'h200000, 27'h5000000, 27'h4800000, 1,1,1, 130);
        tv[2]  = mk(1,0,0, 140,140, 23'h123456, 23'h123456, 27'h491A2B0, 27'h491A2B0, 1,0,0, 140);
        tv[3]  = mk(0,0,0, 200,100, 23'h0,      23'h1,      27'h4000000, 27'h0000001, 0,0,0, 200);
        tv[4]  = mk(0,0,0, 0,  0,   23'h5,      23'h3,      27'h0000028, 27'h0000018, 0,0,0, 0);
        tv[5]  = mk(0,0,0, 30, 6,   23'h0,      23'h0,      27'h4000000, 27'h0000004, 0,0,0, 30);
        tv[6]  = mk(0,0,0, 30, 3,   23'h0,      23'h0,      27'h4000000, 27'h0000001, 0,0,0, 30);
        tv[7]  = mk(0,0,1, 3,  30,  23'h0,      23'h0,      27'h4000000, 27'h0000001, 1,1,1, 30);
        tv[8]  = mk(0,0,0, 40, 8,   23'h0,      23'h2AAAAA, 27'h4000000, 27'h0000001, 0,0,0, 40);
        tv[9]  = mk(0,1,0, 100,101, 23'h0,      23'h0,      27'h4000000, 27'h2000000, 1,0,1, 101);
        tv[10] = mk(0,0,0, 255,254, 23'h0,      23'h0,      27'h4000000, 27'h2000000, 0,0,0, 255);
        tv[11] = mk(0,0,0, 12, 7,   23'h0,      23'h3,      27'h4000000, 27'h0200001, 0,0,0, 12);

        // Reset state
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_sig_large", 32'(sig_large), 32'd0);
        chk("rst_sig_small", 32'(sig_small), 32'd0);
        rst = 1'b0;
        #1 chk("rel_in_ready_now", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_in_ready_next", 32'(in_ready), 32'd1);
        mon_en = 1'b1;
        out_ready = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            apply(tv[i].s, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("tv%0d_lat1", i), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("tv%0d_lat2", i), 32'(out_valid), 32'd1);
            cmp_out($sformatf("tv%0d", i), tv[i].e);
        end
        @(posedge clk); #1;

        // Random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            apply(rand_stim(), 1'(($urandom % 4) != 0));
            out_ready = 1'(($urandom % 4) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("rand_drain", 32'(q.size()), 32'd0);

        // Backpressure: out_ready low for 3 cycles while streaming 4
        for (int i = 0; i < 4; i++) bp[i] = rand_stim();
        k = 0; fell = 1'b0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            out_ready = (c >= 3);
            apply(bp[k], 1'b1);
            @(negedge clk);
            if (!in_ready && !fell) begin
                fell = 1'b1;
                chk("bp_accepts_before_stall", 32'(k), 32'd2);
            end
            if (in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_all_accepted", 32'(k), 32'd4);
        chk("bp_stall_seen", 32'(fell), 32'd1);
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("bp_drain", 32'(q.size()), 32'd0);

        // Reset mid-stream with both stages valid
        out_ready = 1'b0;
        apply(rand_stim(), 1'b1);
        @(posedge clk); #1;
        apply(rand_stim(), 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_out_valid_before", 32'(out_valid), 32'd1);
        chk("mid_in_ready_full", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        mon_en = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sig_large", 32'(sig_large), 32'd0);
        q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        mon_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_no_output%0d", c), 32'(out_valid), 32'd0);
        end
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
